// File: rtl/jt49_eg.sv
// JT49 envelope generator: divides the cen256 time base by the 16-bit envelope
// period and walks a 5-bit level through the AY/YM shape selected on restart.
module jt49_eg #(
    parameter bit STEP4 = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen_eg,
    input  logic [15:0] eg_period,
    input  logic [3:0]  shape,
    input  logic        restart,
    output logic [4:0]  env,
    output logic        cycle_end,
    output logic        holding
);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [4:0] ENV_INC   = STEP4 ? 5'd2 : 5'd1;
    localparam logic [4:0] STEP_LAST = STEP4 ? 5'd30 : 5'd31;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  step_q, step_d;
    logic [3:0]  shape_q, shape_d;
    logic        dir_q, dir_d;
    logic [4:0]  env_q, env_d;
    logic        ce_q, ce_d;
    logic        hold_q, hold_d;

    logic [15:0] per_m1_s;
    logic        step_s;
    logic        last_s;

    // In 16-step mode bit 0 tracks the direction so the level sits on odd/even codes.
    function automatic logic [4:0] fix_env(input logic [4:0] v, input logic up);
        if (STEP4) begin
            fix_env = {v[4:1], up};
        end else begin
            fix_env = v;
        end
    endfunction

    function automatic logic [4:0] start_val(input logic up);
        start_val = fix_env(up ? 5'd0 : 5'd31, up);
    endfunction

    // A zero period behaves as one; >= avoids a long wrap when the period shrinks.
    assign per_m1_s = (eg_period == 16'd0) ? 16'd0 : (eg_period - 16'd1);
    assign step_s   = cen_eg & (cnt_q >= per_m1_s);
    assign last_s   = (step_q >= STEP_LAST);

    // Next-state logic: restart, period counter and envelope stepping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        shape_d = shape_q;
        dir_d   = dir_q;
        env_d   = env_q;
        ce_d    = 1'b0;
        if (restart) begin
            cnt_d   = 16'd0;
            shape_d = shape;
            dir_d   = shape[2];
            step_d  = 5'd0;
            env_d   = start_val(shape[2]);
            state_d = ST_RUN;
        end else begin
            if (cen_eg) begin
                if (step_s) begin
                    cnt_d = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                ST_RUN: begin
                    if (step_s) begin
                        if (last_s) begin
                            ce_d = 1'b1;
                            if (!shape_q[3]) begin
                                env_d   = 5'd0;
                                state_d = ST_HOLD;
                            end else if (shape_q[0]) begin
                                env_d   = (shape_q[2] ^ shape_q[1]) ? 5'd31 : 5'd0;
                                state_d = ST_HOLD;
                            end else begin
                                step_d = 5'd0;
                                dir_d  = dir_q ^ shape_q[1];
                                // On a direction flip the endpoint is held for one step.
                                if (shape_q[1]) begin
                                    env_d = env_q;
                                end else begin
                                    env_d = start_val(dir_q);
                                end
                            end
                        end else begin
                            step_d = step_q + ENV_INC;
                            env_d  = fix_env(dir_q ? (env_q + ENV_INC) : (env_q - ENV_INC), dir_q);
                        end
                    end else begin
                        env_d = env_q;
                    end
                end
                ST_HOLD: begin
                    env_d = env_q;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
        hold_d = (state_d == ST_HOLD);
    end

    // State registers, clocked on the falling edge like the clock-enable divider.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= 16'd0;
            step_q  <= 5'd0;
            shape_q <= 4'd0;
            dir_q   <= 1'b0;
            env_q   <= 5'd0;
            ce_q    <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            shape_q <= shape_d;
            dir_q   <= dir_d;
            env_q   <= env_d;
            ce_q    <= ce_d;
            hold_q  <= hold_d;
        end
    end

    assign env       = env_q;
    assign cycle_end = ce_q;
    assign holding   = hold_q;

endmodule

// File: tb/tb_jt49_eg.sv
// Scoreboard bench for jt49_eg: runs a 32-step and a 16-step instance from the
// same stimulus against a sweep-position model of the envelope.
module tb_jt49_eg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen_eg;
    logic        restart;
    logic [15:0] eg_period;
    logic [3:0]  shape;
    logic [4:0]  env0, env1;
    logic        ce0, ce1, h0, h1;

    jt49_eg #(.STEP4(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cen_eg(cen_eg), .eg_period(eg_period),
        .shape(shape), .restart(restart), .env(env0), .cycle_end(ce0), .holding(h0)
    );

    jt49_eg #(.STEP4(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cen_eg(cen_eg), .eg_period(eg_period),
        .shape(shape), .restart(restart), .env(env1), .cycle_end(ce1), .holding(h1)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [13:0] sb_q[$];

    int          m_cnt;
    int          m_pos;
    logic [3:0]  m_shape;
    logic        m_run[2];
    logic [4:0]  m_env[2];
    logic        m_ce[2];
    logic        m_hold[2];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Level after p steps since restart, for a continuing shape.
    function automatic logic [4:0] env_of(input int cfg, input int p);
        int   len, s, w;
        logic up;
        len = (cfg == 1) ? 16 : 32;
        s   = p / len;
        w   = p % len;
        up  = m_shape[2] ^ (m_shape[1] & (s % 2 == 1));
        if (s > 0 && w == 0 && m_shape[1]) return up ? 5'd0 : 5'd31;
        if (cfg == 0) return up ? 5'(w) : 5'(31 - w);
        return up ? 5'(2 * w + 1) : 5'(30 - 2 * w);
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_pos   = 0;
        m_shape = 4'd0;
        for (int c = 0; c < 2; c++) begin
            m_run[c]  = 1'b0;
            m_env[c]  = 5'd0;
            m_ce[c]   = 1'b0;
            m_hold[c] = 1'b1;
        end
    endtask

    task automatic model_step(input logic cen, input logic rs);
        int   per, len, p;
        logic stp;
        if (rs) begin
            m_cnt   = 0;
            m_pos   = 0;
            m_shape = shape;
            for (int c = 0; c < 2; c++) begin
                m_run[c]  = 1'b1;
                m_ce[c]   = 1'b0;
                m_hold[c] = 1'b0;
                m_env[c]  = env_of(c, 0);
            end
        end else begin
            per = (eg_period == 16'd0) ? 1 : int'(eg_period);
            stp = cen && (m_cnt >= per - 1);
            if (cen) m_cnt = stp ? 0 : m_cnt + 1;
            for (int c = 0; c < 2; c++) begin
                m_ce[c] = 1'b0;
                if (stp && m_run[c]) begin
                    len = (c == 1) ? 16 : 32;
                    p   = m_pos + 1;
                    if (p % len == 0) begin
                        m_ce[c] = 1'b1;
                        if (!m_shape[3]) begin
                            m_env[c] = 5'd0; m_run[c] = 1'b0; m_hold[c] = 1'b1;
                        end else if (m_shape[0]) begin
                            m_env[c] = (m_shape[2] ^ m_shape[1]) ? 5'd31 : 5'd0;
                            m_run[c] = 1'b0; m_hold[c] = 1'b1;
                        end else begin
                            m_env[c] = env_of(c, p);
                        end
                    end else begin
                        m_env[c] = env_of(c, p);
                    end
                end
            end
            if (stp) m_pos++;
        end
    endtask

    task automatic cycle(input logic cen, input logic rs);
        logic [13:0] e;
        cen_eg  = cen;
        restart = rs;
        model_step(cen, rs);
        sb_q.push_back({m_env[0], m_ce[0], m_hold[0], m_env[1], m_ce[1], m_hold[1]});
        @(posedge clk);
        #1;
        cen_eg  = 1'b0;
        restart = 1'b0;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb_q.pop_front();
            check_eq("env",        16'(env0), 16'(e[13:9]));
            check_eq("cycle_end",  16'(ce0),  16'(e[8]));
            check_eq("holding",    16'(h0),   16'(e[7]));
            check_eq("env4",       16'(env1), 16'(e[6:2]));
            check_eq("cycle_end4", 16'(ce1),  16'(e[1]));
            check_eq("holding4",   16'(h1),   16'(e[0]));
        end
    endtask

    task automatic run_cen(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0);
            for (int j = 1; j < gap; j++) cycle(1'b0, 1'b0);
        end
    endtask

    task automatic start(input logic [15:0] per, input logic [3:0] shp);
        eg_period = per;
        shape     = shp;
        cycle(1'b0, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cen_eg    = 1'b0;
        restart   = 1'b0;
        eg_period = 16'd0;
        shape     = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_env",   16'(env0), 16'd0);
        check_eq("rst_ce",    16'(ce0),  16'd0);
        check_eq("rst_hold",  16'(h0),   16'd1);
        check_eq("rst_env4",  16'(env1), 16'd0);
        check_eq("rst_hold4", 16'(h1),   16'd1);
        rst_n = 1'b1;
        model_reset();

        // No restart: stays frozen at zero.
        run_cen(100, 2);

        // Decay then zero, and period 0 behaving as period 1.
        start(16'd1, 4'h0);
        run_cen(40, 4);
        start(16'd0, 4'h0);
        run_cen(40, 2);

        // Attack with CONT=0 drops to zero after the sweep.
        start(16'd1, 4'h4);
        run_cen(40, 1);

        // Sawtooth, triangle, hold-high, attack-hold.
        start(16'd2, 4'hC);
        run_cen(140, 2);
        start(16'd1, 4'hE);
        run_cen(100, 1);
        start(16'd1, 4'hB);
        run_cen(40, 1);
        start(16'd1, 4'hD);
        run_cen(40, 1);

        // Restart colliding with cen_eg.
        eg_period = 16'd3;
        shape     = 4'hC;
        cycle(1'b1, 1'b1);
        run_cen(10, 1);

        // Restart mid-sweep at level 17.
        start(16'd1, 4'hC);
        run_cen(17, 1);
        check_eq("pre_restart_env", 16'(env0), 16'd17);
        start(16'd1, 4'hC);
        run_cen(3, 1);

        // Period lowered below the running count.
        start(16'd100, 4'hC);
        run_cen(50, 1);
        eg_period = 16'd5;
        cycle(1'b1, 1'b0);
        check_eq("lower_step", 16'(env0), 16'd1);
        run_cen(6, 1);

        // Asynchronous reset mid-sweep.
        start(16'd1, 4'hE);
        run_cen(10, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_env",   16'(env0), 16'd0);
        check_eq("arst_hold",  16'(h0),   16'd1);
        check_eq("arst_ce",    16'(ce0),  16'd0);
        check_eq("arst_env4",  16'(env1), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run_cen(5, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
